// File: rtl/decode_issue_ctrl.sv
// Decode-stage controller: decodes fetched bytes into the Decode/Execute latch
// control word, sequences two-byte instructions and interrupt entry.
module decode_issue_ctrl #(
  parameter logic [7:0] INT_VEC = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic       intr,
  output logic       pc_hold,
  output logic [7:0] imm,
  output logic [1:0] ra,
  output logic [1:0] rb,
  output logic       RW,
  output logic       SW1,
  output logic       SW2,
  output logic       out_ld,
  output logic       MW,
  output logic       SM1,
  output logic       SM2,
  output logic       SE1,
  output logic       SE2,
  output logic [1:0] SP,
  output logic [2:0] ALU,
  output logic [4:0] Flags,
  output logic [2:0] BU,
  output logic [1:0] SE3,
  output logic [1:0] SE4
);

  typedef enum logic [1:0] {DEC, IMM, INT1, INT2} state_t;

  typedef struct packed {
    logic [1:0] ra;
    logic [1:0] rb;
    logic       rw;
    logic       sw1;
    logic       sw2;
    logic       out_ld;
    logic       mw;
    logic       sm1;
    logic       sm2;
    logic       se1;
    logic       se2;
    logic [1:0] sp;
    logic [2:0] alu;
    logic [4:0] flags;
    logic [2:0] bu;
  } word_t;

  state_t     state_q, state_d;
  word_t      word_q, word_d;
  word_t      stash_q, stash_d;
  logic [7:0] imm_q, imm_d;
  logic       pc_hold_q, pc_hold_d;
  logic       arm_q, arm_d;
  logic       take_intr;
  logic       two_byte;

  function automatic word_t decode(input logic [7:0] b);
    word_t w;
    logic  nop;
    w    = '0;
    nop  = 1'b0;
    w.ra = b[3:2];
    w.rb = b[1:0];
    case (b[7:4])
      4'h1: w.rw = 1'b1;
      4'h2: begin w.alu = 3'b001; w.rw = 1'b1; w.flags = 5'b11110; end
      4'h3: begin w.alu = 3'b010; w.rw = 1'b1; w.flags = 5'b11110; end
      4'h4: begin w.alu = 3'b011; w.rw = 1'b1; w.flags = 5'b11000; end
      4'h5: begin w.alu = 3'b100; w.rw = 1'b1; w.flags = 5'b11000; end
      4'h6: begin
        w.rw    = 1'b1;
        w.flags = 5'b11110;
        case (b[3:2])
          2'd0:    w.alu = 3'b101;
          2'd1:    w.alu = 3'b110;
          2'd2:    w.alu = 3'b111;
          default: nop = 1'b1;
        endcase
      end
      4'h7: begin
        case (b[3:2])
          2'd0: begin w.mw = 1'b1; w.sm1 = 1'b1; w.sp = 2'b01; end
          2'd1: begin w.rw = 1'b1; w.sw1 = 1'b1; w.sm1 = 1'b1; w.sp = 2'b10; end
          2'd2: w.out_ld = 1'b1;
          default: w.rw = 1'b1;
        endcase
      end
      4'h8: w.bu = {1'b0, b[3:2]} + 3'd1;
      4'h9: begin
        case (b[3:2])
          2'd0: w.bu = 3'b101;
          2'd1: begin
            w.bu = 3'b110; w.mw = 1'b1; w.sm1 = 1'b1; w.sm2 = 1'b1; w.sp = 2'b01;
          end
          2'd2: begin w.bu = 3'b111; w.sw1 = 1'b1; w.sm1 = 1'b1; w.sp = 2'b10; end
          default: begin
            w.bu = 3'b111; w.sw1 = 1'b1; w.sm1 = 1'b1; w.sp = 2'b10; w.flags = 5'b00001;
          end
        endcase
      end
      4'hC: begin w.se1 = 1'b1; w.rw = 1'b1; end
      4'hD: begin w.rw = 1'b1; w.sw1 = 1'b1; end
      4'hE: w.mw = 1'b1;
      default: nop = 1'b1;
    endcase
    if (nop) w = '0;
    return w;
  endfunction

  assign take_intr = intr & arm_q;
  assign two_byte  = (instr[7:4] == 4'hC) || (instr[7:4] == 4'hD) || (instr[7:4] == 4'hE);

  always_comb begin
    state_d   = state_q;
    stash_d   = stash_q;
    imm_d     = imm_q;
    word_d    = '0;
    pc_hold_d = 1'b0;
    // Re-arm only once the request line has been seen low.
    arm_d     = intr ? arm_q : 1'b1;
    if (flush) begin
      if (state_q == IMM) state_d = DEC;
      if (state_q == DEC && take_intr) arm_d = 1'b0;
    end else if (stall) begin
      pc_hold_d = 1'b1;
    end else begin
      case (state_q)
        DEC: begin
          if (take_intr) begin
            state_d   = INT1;
            pc_hold_d = 1'b1;
            arm_d     = 1'b0;
          end else if (instr_valid) begin
            if (two_byte) begin
              stash_d = decode(instr);
              state_d = IMM;
            end else begin
              word_d = decode(instr);
            end
          end
        end
        IMM: begin
          if (instr_valid) begin
            imm_d   = instr;
            word_d  = stash_q;
            state_d = DEC;
          end
        end
        INT1: begin
          word_d.mw  = 1'b1;
          word_d.sm1 = 1'b1;
          word_d.sm2 = 1'b1;
          word_d.sp  = 2'b01;
          pc_hold_d  = 1'b1;
          state_d    = INT2;
        end
        INT2: begin
          word_d.bu = 3'b101;
          imm_d     = INT_VEC;
          pc_hold_d = 1'b1;
          state_d   = DEC;
        end
        default: state_d = DEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DEC;
      word_q    <= '0;
      stash_q   <= '0;
      imm_q     <= '0;
      pc_hold_q <= 1'b0;
      arm_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      stash_q   <= stash_d;
      imm_q     <= imm_d;
      pc_hold_q <= pc_hold_d;
      arm_q     <= arm_d;
    end
  end

  assign pc_hold = pc_hold_q;
  assign imm     = imm_q;
  assign ra      = word_q.ra;
  assign rb      = word_q.rb;
  assign RW      = word_q.rw;
  assign SW1     = word_q.sw1;
  assign SW2     = word_q.sw2;
  assign out_ld  = word_q.out_ld;
  assign MW      = word_q.mw;
  assign SM1     = word_q.sm1;
  assign SM2     = word_q.sm2;
  assign SE1     = word_q.se1;
  assign SE2     = word_q.se2;
  assign SP      = word_q.sp;
  assign ALU     = word_q.alu;
  assign Flags   = word_q.flags;
  assign BU      = word_q.bu;
  assign SE3     = 2'b00;
  assign SE4     = 2'b00;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: each output cycle is compared as one
// packed word against hand-computed values.
module tb_decode_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid, stall, flush, intr;
  logic       pc_hold;
  logic [7:0] imm;
  logic [1:0] ra, rb, SP, SE3, SE4;
  logic       RW, SW1, SW2, out_ld, MW, SM1, SM2, SE1, SE2;
  logic [2:0] ALU, BU;
  logic [4:0] Flags;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] B_NONE = 9'b000000000;
  localparam logic [8:0] B_RW   = 9'b100000000;
  localparam logic [8:0] B_LDM  = 9'b100000010;
  localparam logic [8:0] B_LDD  = 9'b110000000;
  localparam logic [8:0] B_CALL = 9'b000011100;
  localparam logic [8:0] B_RET  = 9'b010001000;
  localparam logic [8:0] B_PUSH = 9'b000011000;

  decode_issue_ctrl #(.INT_VEC(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .intr(intr), .pc_hold(pc_hold), .imm(imm),
    .ra(ra), .rb(rb), .RW(RW), .SW1(SW1), .SW2(SW2), .out_ld(out_ld), .MW(MW),
    .SM1(SM1), .SM2(SM2), .SE1(SE1), .SE2(SE2), .SP(SP), .ALU(ALU),
    .Flags(Flags), .BU(BU), .SE3(SE3), .SE4(SE4)
  );

  always #5 clk = ~clk;

  // bits = {RW,SW1,SW2,out_ld,MW,SM1,SM2,SE1,SE2}
  function automatic logic [38:0] ew(input logic ph, input logic [7:0] im,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [8:0] bits, input logic [1:0] sp,
                                     input logic [2:0] alu, input logic [4:0] fl,
                                     input logic [2:0] bu);
    return {ph, im, a, b, bits, sp, alu, fl, bu, 4'b0000};
  endfunction

  function automatic logic [38:0] obs();
    return {pc_hold, imm, ra, rb, RW, SW1, SW2, out_ld, MW, SM1, SM2, SE1, SE2,
            SP, ALU, Flags, BU, SE3, SE4};
  endfunction

  task automatic check_val(input string tag, input logic [38:0] got, input logic [38:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] i, input logic v);
    instr = i;
    instr_valid = v;
    step();
  endtask

  initial begin
    rst_n = 1'b0; instr = 8'h2E; instr_valid = 1'b1;
    stall = 1'b0; flush = 1'b0; intr = 1'b0;
    step(); step();
    check_val("reset", obs(), '0);

    rst_n = 1'b1;
    step();
    check_val("add_after_reset", obs(), ew(0, 8'h00, 2'd3, 2'd2, B_RW, 2'b00, 3'b001, 5'b11110, 3'b000));

    drive(8'hC1, 1'b1);
    check_val("ldm_byte1", obs(), ew(0, 8'h00, 0, 0, B_NONE, 0, 0, 0, 0));
    drive(8'h5A, 1'b1);
    check_val("ldm_byte2", obs(), ew(0, 8'h5A, 2'd0, 2'd1, B_LDM, 0, 3'b000, 0, 0));

    drive(8'hD0, 1'b1);
    check_val("ldd_byte1", obs(), ew(0, 8'h5A, 0, 0, B_NONE, 0, 0, 0, 0));
    stall = 1'b1;
    drive(8'h33, 1'b1);
    check_val("stall_1", obs(), ew(1, 8'h5A, 0, 0, B_NONE, 0, 0, 0, 0));
    step();
    check_val("stall_2", obs(), ew(1, 8'h5A, 0, 0, B_NONE, 0, 0, 0, 0));
    stall = 1'b0;
    step();
    check_val("ldd_byte2", obs(), ew(0, 8'h33, 0, 0, B_LDD, 0, 0, 0, 0));

    drive(8'hE2, 1'b1);
    check_val("std_byte1", obs(), ew(0, 8'h33, 0, 0, B_NONE, 0, 0, 0, 0));
    flush = 1'b1;
    drive(8'h77, 1'b1);
    check_val("flush_bubble", obs(), ew(0, 8'h33, 0, 0, B_NONE, 0, 0, 0, 0));
    flush = 1'b0;
    drive(8'h10, 1'b1);
    check_val("mov_after_flush", obs(), ew(0, 8'h33, 0, 0, B_RW, 0, 3'b000, 0, 0));

    intr = 1'b1;
    drive(8'h20, 1'b1);
    check_val("intr_entry", obs(), ew(1, 8'h33, 0, 0, B_NONE, 0, 0, 0, 0));
    step();
    check_val("int1_push", obs(), ew(1, 8'h33, 0, 0, B_CALL, 2'b01, 0, 0, 0));
    step();
    check_val("int2_jmp", obs(), ew(1, 8'h01, 0, 0, B_NONE, 0, 0, 0, 3'b101));
    step();
    check_val("add_after_int", obs(), ew(0, 8'h01, 0, 0, B_RW, 0, 3'b001, 5'b11110, 0));
    step();
    check_val("intr_level_no_retake", obs(), ew(0, 8'h01, 0, 0, B_RW, 0, 3'b001, 5'b11110, 0));
    intr = 1'b0;

    drive(8'h90, 1'b1);
    check_val("jmp", obs(), ew(0, 8'h01, 2'd0, 2'd0, B_NONE, 0, 0, 0, 3'b101));
    drive(8'h94, 1'b1);
    check_val("call", obs(), ew(0, 8'h01, 2'd1, 2'd0, B_CALL, 2'b01, 0, 0, 3'b110));
    drive(8'h98, 1'b1);
    check_val("ret", obs(), ew(0, 8'h01, 2'd2, 2'd0, B_RET, 2'b10, 0, 0, 3'b111));
    drive(8'h9C, 1'b1);
    check_val("rti", obs(), ew(0, 8'h01, 2'd3, 2'd0, B_RET, 2'b10, 0, 5'b00001, 3'b111));

    drive(8'h8C, 1'b1);
    check_val("jv", obs(), ew(0, 8'h01, 2'd3, 2'd0, B_NONE, 0, 0, 0, 3'b100));
    drive(8'h71, 1'b1);
    check_val("push", obs(), ew(0, 8'h01, 2'd0, 2'd1, B_PUSH, 2'b01, 0, 0, 0));
    drive(8'h4B, 1'b1);
    check_val("and", obs(), ew(0, 8'h01, 2'd2, 2'd3, B_RW, 0, 3'b011, 5'b11000, 0));
    drive(8'h65, 1'b1);
    check_val("inc", obs(), ew(0, 8'h01, 2'd1, 2'd1, B_RW, 0, 3'b110, 5'b11110, 0));
    drive(8'h6D, 1'b1);
    check_val("unary_nop", obs(), ew(0, 8'h01, 0, 0, B_NONE, 0, 0, 0, 0));
    drive(8'h2E, 1'b0);
    check_val("invalid_bubble", obs(), ew(0, 8'h01, 0, 0, B_NONE, 0, 0, 0, 0));

    intr = 1'b1;
    drive(8'h20, 1'b1);
    check_val("intr_rearmed", obs(), ew(1, 8'h01, 0, 0, B_NONE, 0, 0, 0, 0));
    intr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
